// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: turns a stream of command/data words into timed 16-bit
// 8080-style write cycles and runs the panel hardware-reset sequence after
// prst or a reinit request. The bus is write-only, so srd is held inactive.
//
// Input handshake: a word moves on a rising edge where in_valid and in_ready
// are both 1. in_ready is 1 only in IDLE. A word offered while reinit is
// taken, or while in_ready is 0, is not consumed, and it is never written.
//
// dbg_state exposes the FSM state: 0 RST_ASSERT, 1 RST_WAIT, 2 IDLE,
// 3 SETUP, 4 STROBE, 5 HOLD.
module lcd_bus_writer #(
    parameter int T_SETUP  = 1,
    parameter int T_WRL    = 2,
    parameter int T_WRH    = 2,
    parameter int RST_LOW  = 100,
    parameter int RST_WAIT = 1000
) (
    input  logic        pclk,
    input  logic        prst,
    input  logic        in_valid,
    input  logic        in_rs,
    input  logic [15:0] in_data,
    output logic        in_ready,
    input  logic        reinit,
    input  logic        bl_on,
    output logic        busy,
    output logic        sblk,
    output logic        scs,
    output logic        srs,
    output logic        swr,
    output logic        srd,
    output logic        srst,
    output logic [15:0] sdata,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_RST_ASSERT = 3'd0,
        S_RST_WAIT   = 3'd1,
        S_IDLE       = 3'd2,
        S_SETUP      = 3'd3,
        S_STROBE     = 3'd4,
        S_HOLD       = 3'd5
    } state_t;

    // Last counter value of each timed state; the counter runs 0..N-1.
    localparam logic [15:0] SETUP_LAST    = 16'(T_SETUP - 1);
    localparam logic [15:0] WRL_LAST      = 16'(T_WRL - 1);
    localparam logic [15:0] WRH_LAST      = 16'(T_WRH - 1);
    localparam logic [15:0] RST_LOW_LAST  = 16'(RST_LOW - 1);
    localparam logic [15:0] RST_WAIT_LAST = 16'(RST_WAIT - 1);

    state_t      state;
    state_t      state_nx;
    logic [15:0] cnt;
    logic [15:0] cnt_nx;
    logic        accept;

    // State register and the single counter shared by every timed state.
    always_ff @(posedge pclk) begin
        if (prst) begin
            state <= S_RST_ASSERT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic: each timed state lasts until its counter hits the
    // last value, then the counter is cleared for the state being entered.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 16'd1;
        accept   = 1'b0;
        case (state)
            S_RST_ASSERT: begin
                if (cnt == RST_LOW_LAST) begin
                    state_nx = S_RST_WAIT;
                    cnt_nx   = '0;
                end
            end
            S_RST_WAIT: begin
                if (cnt == RST_WAIT_LAST) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end
            end
            S_IDLE: begin
                cnt_nx = '0;
                // reinit wins over a pending word; the word stays unconsumed.
                if (reinit) begin
                    state_nx = S_RST_ASSERT;
                end else if (in_valid && in_ready) begin
                    accept   = 1'b1;
                    state_nx = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_nx = S_STROBE;
                    cnt_nx   = '0;
                end
            end
            S_STROBE: begin
                if (cnt == WRL_LAST) begin
                    state_nx = S_HOLD;
                    cnt_nx   = '0;
                end
            end
            S_HOLD: begin
                if (cnt == WRH_LAST) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = S_RST_ASSERT;
                cnt_nx   = '0;
            end
        endcase
    end

    // Control outputs are registered from the next state so every pin is a
    // flop and lines up with the state it belongs to.
    always_ff @(posedge pclk) begin
        if (prst) begin
            srst     <= 1'b0;
            scs      <= 1'b1;
            swr      <= 1'b1;
            in_ready <= 1'b0;
            busy     <= 1'b1;
        end else begin
            srst     <= (state_nx != S_RST_ASSERT);
            scs      <= !((state_nx == S_SETUP) || (state_nx == S_STROBE) ||
                          (state_nx == S_HOLD));
            swr      <= (state_nx != S_STROBE);
            in_ready <= (state_nx == S_IDLE);
            busy     <= (state_nx != S_IDLE);
        end
    end

    // Bus word: captured only when a word is accepted, held through the
    // write cycle and kept in IDLE; only prst clears it.
    always_ff @(posedge pclk) begin
        if (prst) begin
            srs   <= 1'b0;
            sdata <= '0;
        end else if (accept) begin
            srs   <= in_rs;
            sdata <= in_data;
        end
    end

    // Backlight follows bl_on one cycle later, independent of the FSM.
    always_ff @(posedge pclk) begin
        if (prst) begin
            sblk <= 1'b0;
        end else begin
            sblk <= bl_on;
        end
    end

    // No reads and no bus turnaround: the read strobe stays inactive.
    assign srd       = 1'b1;
    assign dbg_state = state;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Bench for lcd_bus_writer: two instances share clock, prst and bl_on.
// Instance 0 uses the default write timing, instance 1 uses
// T_SETUP=3, T_WRL=1, T_WRH=4. Both use RST_LOW=4, RST_WAIT=6.
module tb_lcd_bus_writer;

  localparam int RL   = 4;
  localparam int RW   = 6;
  localparam int TS_A = 1;
  localparam int TL_A = 2;
  localparam int TH_A = 2;
  localparam int TS_B = 3;
  localparam int TL_B = 1;
  localparam int TH_B = 4;

  // clock / reset
  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic        prst;
  logic        bl_on;
  logic [1:0]  in_valid;
  logic [1:0]  in_rs;
  logic [1:0]  reinit;
  logic [15:0] in_data [2];
  logic [1:0]  in_ready;
  logic [1:0]  busy;
  logic [1:0]  sblk;
  logic [1:0]  scs;
  logic [1:0]  srs;
  logic [1:0]  swr;
  logic [1:0]  srd;
  logic [1:0]  srst;
  logic [15:0] sdata [2];
  logic [2:0]  dbg_state [2];

  int checks = 0;
  int errors = 0;

  // scoreboard: {srs, sdata} expected at each swr rising edge
  logic [16:0] exp_q_a[$];
  logic [16:0] exp_q_b[$];
  logic [16:0] want;
  logic [1:0]  swr_prev = 2'b11;

  lcd_bus_writer #(
    .T_SETUP(TS_A), .T_WRL(TL_A), .T_WRH(TH_A), .RST_LOW(RL), .RST_WAIT(RW)
  ) dut_a (
    .pclk(pclk), .prst(prst), .in_valid(in_valid[0]), .in_rs(in_rs[0]),
    .in_data(in_data[0]), .in_ready(in_ready[0]), .reinit(reinit[0]),
    .bl_on(bl_on), .busy(busy[0]), .sblk(sblk[0]), .scs(scs[0]),
    .srs(srs[0]), .swr(swr[0]), .srd(srd[0]), .srst(srst[0]),
    .sdata(sdata[0]), .dbg_state(dbg_state[0])
  );

  lcd_bus_writer #(
    .T_SETUP(TS_B), .T_WRL(TL_B), .T_WRH(TH_B), .RST_LOW(RL), .RST_WAIT(RW)
  ) dut_b (
    .pclk(pclk), .prst(prst), .in_valid(in_valid[1]), .in_rs(in_rs[1]),
    .in_data(in_data[1]), .in_ready(in_ready[1]), .reinit(reinit[1]),
    .bl_on(bl_on), .busy(busy[1]), .sblk(sblk[1]), .scs(scs[1]),
    .srs(srs[1]), .swr(swr[1]), .srd(srd[1]), .srst(srst[1]),
    .sdata(sdata[1]), .dbg_state(dbg_state[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // scoreboard pop: a panel write happens on swr rising while srst is high
  always @(negedge pclk) begin
    for (int d = 0; d < 2; d++) begin
      if (swr[d] === 1'b1 && swr_prev[d] === 1'b0 && srst[d] === 1'b1) begin
        if (d == 0) begin
          check("sb_a_expected", 32'(exp_q_a.size() != 0), 1);
          if (exp_q_a.size() != 0) begin
            want = exp_q_a.pop_front();
            check("sb_a_word", {srs[0], sdata[0]}, want);
          end
        end else begin
          check("sb_b_expected", 32'(exp_q_b.size() != 0), 1);
          if (exp_q_b.size() != 0) begin
            want = exp_q_b.pop_front();
            check("sb_b_word", {srs[1], sdata[1]}, want);
          end
        end
      end
    end
    swr_prev = swr;
  end

  // Reset sequence starting in the first RST_ASSERT cycle (k=0).
  task automatic rst_seq(input string t, input logic [1:0] mask);
    for (int k = 0; k < RL + RW; k++) begin
      for (int b = 0; b < 2; b++) begin
        if (mask[b]) begin
          if (k == 0) check({t, "_dbg_rst"}, dbg_state[b], 0);
          check({t, "_srst"}, srst[b], 32'(k >= RL));
          check({t, "_ready"}, in_ready[b], 0);
          check({t, "_busy"}, busy[b], 1);
          check({t, "_scs"}, scs[b], 1);
          check({t, "_swr"}, swr[b], 1);
          check({t, "_srd"}, srd[b], 1);
          if (k > 0) check({t, "_sblk"}, sblk[b], bl_on);
        end
      end
      step();
    end
    for (int b = 0; b < 2; b++) begin
      if (mask[b]) begin
        check({t, "_ready_up"}, in_ready[b], 1);
        check({t, "_busy_idle"}, busy[b], 0);
        check({t, "_srst_up"}, srst[b], 1);
        check({t, "_scs_idle"}, scs[b], 1);
        check({t, "_dbg_idle"}, dbg_state[b], 2);
      end
    end
  endtask

  // One write cycle, starting in the cycle after the accept edge (k=0) and
  // ending in the IDLE cycle that follows HOLD. bl_on is toggled randomly.
  task automatic check_write(input string t, input int b, input int ts, input int twl,
                             input int twh, input logic rs, input logic [15:0] data,
                             input int pulse_k);
    int total;
    total = ts + twl + twh;
    for (int k = 0; k <= total; k++) begin
      check({t, "_scs"}, scs[b], 32'(k == total));
      check({t, "_swr"}, swr[b], 32'(!(k >= ts && k < ts + twl)));
      check({t, "_ready"}, in_ready[b], 32'(k == total));
      check({t, "_busy"}, busy[b], 32'(k != total));
      check({t, "_srs"}, srs[b], rs);
      check({t, "_sdata"}, sdata[b], data);
      check({t, "_srst"}, srst[b], 1);
      check({t, "_srd"}, srd[b], 1);
      check({t, "_sblk"}, sblk[b], bl_on);
      if (k < total) begin
        bl_on = 1'($urandom_range(0, 1));
        reinit[b] = (k == pulse_k);
        step();
      end
    end
    reinit[b] = 1'b0;
  endtask

  initial begin
    prst       = 1'b1;
    bl_on      = 1'b1;
    in_valid   = '0;
    in_rs      = '0;
    reinit     = '0;
    in_data[0] = '0;
    in_data[1] = '0;

    // 1: reset held 3 cycles; bl_on ignored while prst is high
    repeat (3) step();
    for (int b = 0; b < 2; b++) begin
      check("rst_srst", srst[b], 0);
      check("rst_scs", scs[b], 1);
      check("rst_swr", swr[b], 1);
      check("rst_srd", srd[b], 1);
      check("rst_srs", srs[b], 0);
      check("rst_sdata", sdata[b], 0);
      check("rst_sblk", sblk[b], 0);
      check("rst_ready", in_ready[b], 0);
      check("rst_busy", busy[b], 1);
    end
    prst = 1'b0;
    rst_seq("t1", 2'b11);

    // 2: single command word
    in_valid[0] = 1'b1; in_rs[0] = 1'b0; in_data[0] = 16'h002C;
    exp_q_a.push_back({1'b0, 16'h002C});
    step();
    in_valid[0] = 1'b0;
    check_write("t2", 0, TS_A, TL_A, TH_A, 1'b0, 16'h002C, -1);

    // 3: back-to-back data words with in_valid held high
    in_valid[0] = 1'b1; in_rs[0] = 1'b1; in_data[0] = 16'h1234;
    exp_q_a.push_back({1'b1, 16'h1234});
    step();
    in_data[0] = 16'h5678;
    exp_q_a.push_back({1'b1, 16'h5678});
    check_write("t3a", 0, TS_A, TL_A, TH_A, 1'b1, 16'h1234, -1);
    step();
    in_valid[0] = 1'b0;
    check_write("t3b", 0, TS_A, TL_A, TH_A, 1'b1, 16'h5678, -1);

    // 5a: reinit together with in_valid in IDLE: word dropped, reset rerun
    in_valid[0] = 1'b1; in_rs[0] = 1'b0; in_data[0] = 16'hBEEF; reinit[0] = 1'b1;
    step();
    in_valid[0] = 1'b0; reinit[0] = 1'b0;
    check("t5_sdata_kept", sdata[0], 16'h5678);
    check("t5_srs_kept", srs[0], 1);
    rst_seq("t5", 2'b01);
    check("t5_sdata_after", sdata[0], 16'h5678);

    // 5b: reinit during STROBE is ignored
    in_valid[0] = 1'b1; in_rs[0] = 1'b1; in_data[0] = 16'h00A5;
    exp_q_a.push_back({1'b1, 16'h00A5});
    step();
    in_valid[0] = 1'b0;
    check_write("t5b", 0, TS_A, TL_A, TH_A, 1'b1, 16'h00A5, TS_A);

    // 6: other timing parameters, two back-to-back words
    in_valid[1] = 1'b1; in_rs[1] = 1'b0; in_data[1] = 16'h002C;
    exp_q_b.push_back({1'b0, 16'h002C});
    step();
    in_data[1] = 16'h9ABC;
    exp_q_b.push_back({1'b0, 16'h9ABC});
    check_write("t6a", 1, TS_B, TL_B, TH_B, 1'b0, 16'h002C, -1);
    step();
    in_valid[1] = 1'b0;
    check_write("t6b", 1, TS_B, TL_B, TH_B, 1'b0, 16'h9ABC, -1);

    // 4: prst while swr is low aborts the cycle; the word is never written
    in_valid[0] = 1'b1; in_rs[0] = 1'b1; in_data[0] = 16'h7777;
    step();
    in_valid[0] = 1'b0;
    repeat (TS_A) step();
    check("t4_swr_low", swr[0], 0);
    prst = 1'b1;
    step();
    prst = 1'b0;
    check("t4_swr", swr[0], 1);
    check("t4_scs", scs[0], 1);
    check("t4_srst", srst[0], 0);
    check("t4_sdata", sdata[0], 0);
    check("t4_srs", srs[0], 0);
    check("t4_ready", in_ready[0], 0);
    check("t4_busy", busy[0], 1);
    rst_seq("t4", 2'b11);
    in_valid[0] = 1'b1; in_rs[0] = 1'b1; in_data[0] = 16'h4321;
    exp_q_a.push_back({1'b1, 16'h4321});
    step();
    in_valid[0] = 1'b0;
    check_write("t4w", 0, TS_A, TL_A, TH_A, 1'b1, 16'h4321, -1);

    // drain and final report
    repeat (3) step();
    check("sb_a_drained", exp_q_a.size(), 0);
    check("sb_b_drained", exp_q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
